// File: rtl/ifm_window_stream_ctrl_if.sv
// IFM read port plus FIFO push / window-tag bus of the window stream controller.
interface ifm_window_stream_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SEL_WIDTH    = 2,
    parameter int OFM_WIDTH    = 7,
    parameter int FILTER_WIDTH = 1
) ();
    logic                    ifm_rd_en;
    logic [ADDR_WIDTH-1:0]   ifm_rd_addr;
    logic [SEL_WIDTH-1:0]    ifm_sel;
    logic [DATA_WIDTH-1:0]   ifm_rd_data;
    logic                    fifo_enable;
    logic [DATA_WIDTH-1:0]   fifo_data_in;
    logic                    window_valid;
    logic [OFM_WIDTH-1:0]    ofm_addr;
    logic [FILTER_WIDTH-1:0] filter_idx;
    logic                    first_channel;
    logic                    last_channel;

    modport master (
        output ifm_rd_en, ifm_rd_addr, ifm_sel,
        input  ifm_rd_data,
        output fifo_enable, fifo_data_in,
        output window_valid, ofm_addr, filter_idx, first_channel, last_channel
    );

    modport slave (
        input  ifm_rd_en, ifm_rd_addr, ifm_sel,
        output ifm_rd_data,
        input  fifo_enable, fifo_data_in,
        input  window_valid, ofm_addr, filter_idx, first_channel, last_channel
    );
endinterface

// File: rtl/ifm_window_stream_ctrl.sv
// Streams every IFM pixel per filter/channel into the conv line-buffer FIFO and tags complete windows.
// IFM_STREAM_WINDOW_CNT_EN adds a 32-bit window_count output.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_STREAM | one IFM read per cycle over filter/channel/pixel
// S_DRAIN  | 2 cycles letting the push and window stages empty
// S_DONE   | single-cycle done pulse
module ifm_window_stream_ctrl #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 3,
    parameter int KERNAL_SIZE           = 5,
    parameter int NUMBER_OF_FILTERS     = 2,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
`ifdef IFM_STREAM_WINDOW_CNT_EN
    output logic [31:0] window_count,
`endif
    ifm_window_stream_ctrl_if.master bus
);
    localparam int RC_W  = $clog2(IFM_SIZE);
    localparam int SEL_W = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam int FLT_W = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(IFM_SIZE - 1);
    localparam logic [RC_W-1:0]  K_LAST  = RC_W'(KERNAL_SIZE - 1);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(IFM_DEPTH - 1);
    localparam logic [FLT_W-1:0] F_LAST  = FLT_W'(NUMBER_OF_FILTERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;
    logic   drain_cnt;

    logic [RC_W-1:0]                  col, row;
    logic [ADDRESS_SIZE_IFM-1:0]      pix;
    logic [SEL_W-1:0]                 ch;
    logic [FLT_W-1:0]                 flt;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_cnt;
    logic                             rd_en;

    logic                             push_en, push_win, push_first, push_last;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] push_ofm;
    logic [FLT_W-1:0]                 push_flt;

    logic                             win_valid, win_first, win_last;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] win_ofm;
    logic [FLT_W-1:0]                 win_flt;

    logic row_end, chan_end, last_rd, win_pix;
    assign row_end  = (col == RC_LAST);
    assign chan_end = row_end && (row == RC_LAST);
    assign last_rd  = (state == S_STREAM) && chan_end && (ch == CH_LAST) && (flt == F_LAST);
    assign win_pix  = (row >= K_LAST) && (col >= K_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_STREAM;
            S_STREAM: if (last_rd) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == S_DRAIN) && !drain_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            col        <= '0;
            row        <= '0;
            pix        <= '0;
            ch         <= '0;
            flt        <= '0;
            ofm_cnt    <= '0;
            push_en    <= 1'b0;
            push_win   <= 1'b0;
            push_first <= 1'b0;
            push_last  <= 1'b0;
            push_ofm   <= '0;
            push_flt   <= '0;
            win_valid  <= 1'b0;
            win_first  <= 1'b0;
            win_last   <= 1'b0;
            win_ofm    <= '0;
            win_flt    <= '0;
        end else begin
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_DONE);
            rd_en <= (state_nxt == S_STREAM);

            // Counters sit at zero outside a run so the read bus idles at address 0.
            if ((state == S_IDLE && start) || last_rd) begin
                col     <= '0;
                row     <= '0;
                pix     <= '0;
                ch      <= '0;
                flt     <= '0;
                ofm_cnt <= '0;
            end else if (state == S_STREAM) begin
                col     <= row_end ? '0 : col + RC_W'(1);
                pix     <= chan_end ? '0 : pix + ADDRESS_SIZE_IFM'(1);
                ofm_cnt <= chan_end ? '0 :
                           (win_pix ? ofm_cnt + ADDRESS_SIZE_NEXT_IFM'(1) : ofm_cnt);
                if (row_end) row <= (row == RC_LAST) ? '0 : row + RC_W'(1);
                if (chan_end) begin
                    ch <= (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
                    if (ch == CH_LAST) flt <= flt + FLT_W'(1);
                end
            end

            push_en <= rd_en;
            if (rd_en) begin
                push_win   <= win_pix;
                push_ofm   <= ofm_cnt;
                push_flt   <= flt;
                push_first <= (ch == '0);
                push_last  <= (ch == CH_LAST);
            end

            win_valid <= push_en && push_win;
            if (push_en && push_win) begin
                win_ofm   <= push_ofm;
                win_flt   <= push_flt;
                win_first <= push_first;
                win_last  <= push_last;
            end
        end
    end

`ifdef IFM_STREAM_WINDOW_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     window_count <= '0;
        else if (state == S_IDLE && start) window_count <= '0;
        else if (win_valid)             window_count <= window_count + 32'd1;
    end
`endif

    assign bus.ifm_rd_en     = rd_en;
    assign bus.ifm_rd_addr   = pix;
    assign bus.ifm_sel       = ch;
    assign bus.fifo_enable   = push_en;
    // Read data is only meaningful while a push is in flight; discard it otherwise.
    assign bus.fifo_data_in  = push_en ? bus.ifm_rd_data : {DATA_WIDTH{1'b0}};
    assign bus.window_valid  = win_valid;
    assign bus.ofm_addr      = win_ofm;
    assign bus.filter_idx    = win_flt;
    assign bus.first_channel = win_first;
    assign bus.last_channel  = win_last;
endmodule

// File: tb/tb_ifm_window_stream_ctrl.sv
// Randomized bench for ifm_window_stream_ctrl against a cycle-indexed arithmetic reference.
module tb_ifm_window_stream_ctrl;
    localparam int DW   = 32;
    localparam int S    = 14;
    localparam int D    = 3;
    localparam int K    = 5;
    localparam int F    = 2;
    localparam int SN   = S - K + 1;
    localparam int SS   = S * S;
    localparam int N    = F * D * SS;
    localparam int AW   = 8;
    localparam int NW   = 7;
    localparam int SELW = 2;
    localparam int FW   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
`ifdef IFM_STREAM_WINDOW_CNT_EN
    logic [31:0] window_count;
`endif

    ifm_window_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SELW),
                                .OFM_WIDTH(NW), .FILTER_WIDTH(FW)) bus ();

    ifm_window_stream_ctrl dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef IFM_STREAM_WINDOW_CNT_EN
        .window_count (window_count),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [D][SS];
    always @(posedge clk)
        bus.ifm_rd_data <= bus.ifm_rd_en ? mem[bus.ifm_sel][bus.ifm_rd_addr] : $urandom();

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit active = 1'b0;
    bit run_over = 1'b0;
    int win_total, last_ofm, last_flt;
    int first_cnt [F];
    int last_cnt [F];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, act, req, cyc - t0 + 1);
        end
    endtask

    always @(posedge clk) begin
        int t, i, p, ch, r, c, fl;
        bit e_rd, e_push, e_win;
        cyc = cyc + 1;
        #1;
        if (active) begin
            t = cyc - t0 + 1;
            e_rd = (t >= 1) && (t <= N);
            check_val("ifm_rd_en", bus.ifm_rd_en, e_rd);
            if (e_rd) begin
                i = t - 1; p = i % SS; ch = (i / SS) % D;
                check_val("ifm_rd_addr", bus.ifm_rd_addr, p);
                check_val("ifm_sel", bus.ifm_sel, ch);
            end
            e_push = (t >= 2) && (t <= N + 1);
            check_val("fifo_enable", bus.fifo_enable, e_push);
            if (e_push) begin
                i = t - 2; p = i % SS; ch = (i / SS) % D;
                check_val("fifo_data_in", bus.fifo_data_in, mem[ch][p]);
            end
            e_win = 1'b0;
            if (t >= 3 && t <= N + 2) begin
                i = t - 3; p = i % SS; r = p / S; c = p % S;
                ch = (i / SS) % D; fl = i / (SS * D);
                e_win = (r >= K - 1) && (c >= K - 1);
            end
            check_val("window_valid", bus.window_valid, e_win);
            if (e_win) begin
                check_val("ofm_addr", bus.ofm_addr, (r - K + 1) * SN + (c - K + 1));
                check_val("filter_idx", bus.filter_idx, fl);
                check_val("first_channel", bus.first_channel, ch == 0);
                check_val("last_channel", bus.last_channel, ch == D - 1);
            end
            check_val("busy", busy, (t >= 1) && (t <= N + 3));
            check_val("done", done, t == N + 3);
`ifdef IFM_STREAM_WINDOW_CNT_EN
            if (t == 1)     check_val("window_count_clear", window_count, 0);
            if (t == N + 3) check_val("window_count_final", window_count, F * D * SN * SN);
`endif
            if (bus.window_valid === 1'b1) begin
                win_total++;
                if (bus.first_channel === 1'b1) first_cnt[bus.filter_idx]++;
                if (bus.last_channel === 1'b1)  last_cnt[bus.filter_idx]++;
                last_ofm = int'(bus.ofm_addr);
                last_flt = int'(bus.filter_idx);
            end
            if (t >= N + 4) run_over = 1'b1;
        end
    end

    task automatic arm_run;
        for (int d = 0; d < D; d++)
            for (int p = 0; p < SS; p++)
                mem[d][p] = $urandom();
        win_total = 0; last_ofm = -1; last_flt = -1;
        for (int f = 0; f < F; f++) begin first_cnt[f] = 0; last_cnt[f] = 0; end
        t0 = cyc + 1;
        run_over = 1'b0;
        active = 1'b1;
    endtask

    task automatic wait_run(input bit poke);
        int lbl;
        for (int k = 0; k < N + 100; k++) begin
            @(negedge clk);
            if (poke) start = 1'b0;
            if (run_over) break;
            lbl = cyc - t0 + 1;
            if (poke && lbl >= 1 && lbl < N && $urandom_range(0, 15) == 0) start = 1'b1;
        end
        if (!run_over) check_val("run_timeout", 0, 1);
        check_val("windows_total", win_total, F * D * SN * SN);
        for (int f = 0; f < F; f++) begin
            check_val("windows_first_ch", first_cnt[f], SN * SN);
            check_val("windows_last_ch", last_cnt[f], SN * SN);
        end
        check_val("last_ofm_addr", last_ofm, SN * SN - 1);
        check_val("last_filter_idx", last_flt, F - 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rd_en"}, bus.ifm_rd_en, 0);
        check_val({tag, "_rd_addr"}, bus.ifm_rd_addr, 0);
        check_val({tag, "_sel"}, bus.ifm_sel, 0);
        check_val({tag, "_fifo_enable"}, bus.fifo_enable, 0);
        check_val({tag, "_fifo_data_in"}, bus.fifo_data_in, 0);
        check_val({tag, "_window_valid"}, bus.window_valid, 0);
        check_val({tag, "_ofm_addr"}, bus.ofm_addr, 0);
        check_val({tag, "_filter_idx"}, bus.filter_idx, 0);
        check_val({tag, "_first_channel"}, bus.first_channel, 0);
        check_val({tag, "_last_channel"}, bus.last_channel, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
`ifdef IFM_STREAM_WINDOW_CNT_EN
        check_val({tag, "_window_count"}, window_count, 0);
`endif
    endtask

    initial begin
        int rc, lbl;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single launch with stray start pulses while busy.
        start = 1'b1;
        arm_run();
        @(negedge clk);
        start = 1'b0;
        wait_run(1'b1);

        // start held high: relaunch right after returning to IDLE.
        @(negedge clk);
        start = 1'b1;
        arm_run();
        wait_run(1'b0);
        arm_run();
        @(negedge clk);
        start = 1'b0;
        wait_run(1'b0);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        arm_run();
        @(negedge clk);
        start = 1'b0;
        rc = $urandom_range(300, 700);
        for (int k = 0; k < N; k++) begin
            lbl = cyc - t0 + 1;
            if (lbl >= rc) break;
            @(negedge clk);
        end
        active = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("post_reset_busy", busy, 0);
            check_val("post_reset_rd_en", bus.ifm_rd_en, 0);
            check_val("post_reset_fifo_enable", bus.fifo_enable, 0);
        end

        start = 1'b1;
        arm_run();
        @(negedge clk);
        start = 1'b0;
        wait_run(1'b1);

        active = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
